if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Front-end sequencer for the pipelined CPU. It drives the IF/PC enable and the
//  IF/ID, ID/EX and EX/MEM flush/enable controls. It arbitrates between branch/jump
//  redirects resolved in MEM, load-use stalls from ID, multi-cycle instruction-memory
//  waits and an external halt. It also keeps saturating stall and redirect counters.
// PARAMETERS
//  CNT_W     32  width of Stall_Cnt and Flush_Cnt
//  WAIT_MAX  15  consecutive WAIT cycles before Timeout sets (range 1..255)
// PORTS
//  Clk          in   1      clock, all state updates on posedge
//  Rst          in   1      reset, synchronous, active-high
//  MEM_PCSrc    in   1      taken branch/jump resolved in MEM; target is already on the PC mux
//  ID_LoadUse   in   1      load-use hazard detected in ID
//  IMEM_Ready   in   1      instruction memory has valid data for the current PC
//  Halt_Req     in   1      external/debug halt request, level
//  IF_EN        out  1      PC/IF register update enable
//  IFID_EN      out  1      IF/ID register enable
//  IFID_Flush   out  1      load NOP into IF/ID
//  IDEX_Flush   out  1      load bubble into ID/EX
//  EXMEM_Flush  out  1      load bubble into EX/MEM
//  Halted       out  1      registered, 1 while State==HALT
//  Timeout      out  1      sticky, registered
//  State        out  2      registered FSM state: RUN=0, WAIT=2, HALT=3 (code 1 unused)
//  Stall_Cnt    out  CNT_W  cycles with IF_EN==0 outside reset, saturating
//  Flush_Cnt    out  CNT_W  redirect events, saturating
// BEHAVIOUR
//  Reset (Rst=1 at posedge):
//   - State=RUN; Halted, Timeout, Stall_Cnt, Flush_Cnt and wait counter all 0.
//   - While Rst=1 the combinational outputs are IF_EN=0, IFID_EN=0 and all flushes 0.
//   - Rst overrides every input in the same cycle, including mid-WAIT and mid-HALT.
//  Outputs IF_EN, IFID_EN and the flushes are combinational (Mealy) from State and inputs.
//   - Defaults: IF_EN=1, IFID_EN=1, flushes 0.
//  Redirect (MEM_PCSrc=1) has top priority in every state:
//   - IF_EN=1, IFID_EN=1, IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1.
//   - Flush_Cnt+1. Wait counter clears.
//   - Next state: HALT if Halt_Req=1 or State==HALT; otherwise RUN.
//   - ID_LoadUse and IMEM_Ready are ignored in that cycle.
//  RUN:
//   - Halt_Req=1: IF_EN=0, IFID_EN=0, IDEX_Flush=1; next state HALT.
//   - else IMEM_Ready=0: IF_EN=0, IFID_Flush=1; next state WAIT; wait counter=1.
//   - else ID_LoadUse=1: IF_EN=0, IFID_EN=0, IDEX_Flush=1 for that cycle only; stay RUN.
//   - else normal flow.
//  WAIT:
//   - IMEM_Ready=1: normal flow; next state RUN; wait counter clears.
//     Halt_Req in this cycle is taken next cycle from RUN.
//   - IMEM_Ready=0: IF_EN=0, IFID_Flush=1; wait counter+1, saturating at 255.
//     Timeout sets once the counter reaches WAIT_MAX; stay WAIT.
//   - ID_LoadUse is ignored, because IF/ID already holds a bubble.
//  HALT:
//   - IF_EN=0, IFID_EN=0, IDEX_Flush=1, so the back end drains.
//   - Halt_Req=0 -> next state RUN, and fetch resumes at the held PC.
//  Counters:
//   - Stall_Cnt+1 on every non-reset cycle with IF_EN=0. Both counters hold at all-ones.
// TESTING
//  1. Rst=1 for 2 cycles, then Rst=0 with IMEM_Ready=1 and all other inputs 0
//     -> IF_EN=1, IFID_EN=1, flushes 0, State=0, counters 0.
//  2. RUN, pulse ID_LoadUse for 1 cycle -> exactly that cycle IF_EN=0, IFID_EN=0,
//     IDEX_Flush=1; Stall_Cnt=1; State stays 0.
//  3. IMEM_Ready=0 for 3 cycles, then 1 -> State=2 for 3 cycles; IFID_Flush=1 in those
//     cycles; Stall_Cnt=3; State returns to 0.
//  4. MEM_PCSrc=1 with ID_LoadUse=1 and IMEM_Ready=0 in the same cycle -> IF_EN=1, all
//     three flushes 1, Flush_Cnt=1, next State=0.
//  5. Halt_Req=1 for 5 cycles with a MEM_PCSrc pulse in cycle 3 -> Halted=1 from
//     cycle 2; cycle 3 has IF_EN=1 and all flushes 1; State stays 3; RUN once
//     Halt_Req=0.
//  6. IMEM_Ready=0 for 20 cycles with WAIT_MAX=15 -> Timeout rises after the 15th WAIT
//     cycle and stays 1 until Rst; Rst asserted mid-WAIT -> State=0 next cycle.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : Front-end sequencer. Handles PC/IF enable and pipeline flush
//           arbitration for redirects, load-use stalls, IMEM waits and halt.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             MEM_PCSrc,
  input  logic             ID_LoadUse,
  input  logic             IMEM_Ready,
  input  logic             Halt_Req,
  output logic             IF_EN,
  output logic             IFID_EN,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             Halted,
  output logic             Timeout,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [1:0]       c_RUN      = 2'd0;
  localparam logic [1:0]       c_WAIT     = 2'd2;
  localparam logic [1:0]       c_HALT     = 2'd3;
  localparam logic [7:0]       c_WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= c_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect wins everywhere; a pending halt survives it so the core stays parked.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (MEM_PCSrc) begin
      w_wait_nxt  = 8'd0;
      w_state_nxt = (Halt_Req || (r_state == c_HALT)) ? c_HALT : c_RUN;
    end else begin
      case (r_state)
        c_RUN: begin
          if (Halt_Req) begin
            w_state_nxt = c_HALT;
          end else if (!IMEM_Ready) begin
            w_state_nxt = c_WAIT;
            w_wait_nxt  = 8'd1;
          end
        end
        c_WAIT: begin
          if (IMEM_Ready) begin
            w_state_nxt = c_RUN;
            w_wait_nxt  = 8'd0;
          end else if (r_wait_cnt != 8'hFF) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end
        c_HALT: begin
          if (!Halt_Req) begin
            w_state_nxt = c_RUN;
          end
        end
        default: begin
          w_state_nxt = c_RUN;
          w_wait_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    IF_EN       = 1'b1;
    IFID_EN     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (Rst) begin
      IF_EN   = 1'b0;
      IFID_EN = 1'b0;
    end else if (MEM_PCSrc) begin
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else begin
      case (r_state)
        c_RUN: begin
          if (Halt_Req || (IMEM_Ready && ID_LoadUse)) begin
            IF_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_Flush = 1'b1;
          end else if (!IMEM_Ready) begin
            IF_EN      = 1'b0;
            IFID_Flush = 1'b1;
          end
        end
        // IF/ID already carries a bubble here, so a load-use hazard is moot.
        c_WAIT: begin
          if (!IMEM_Ready) begin
            IF_EN      = 1'b0;
            IFID_Flush = 1'b1;
          end
        end
        c_HALT: begin
          IF_EN      = 1'b0;
          IFID_EN    = 1'b0;
          IDEX_Flush = 1'b1;
        end
        default: begin
          IF_EN   = 1'b1;
          IFID_EN = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt >= c_WAIT_LIM) begin
        r_timeout <= 1'b1;
      end
      if (!IF_EN && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (MEM_PCSrc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign State     = r_state;
  assign Halted    = (r_state == c_HALT);
  assign Timeout   = r_timeout;
  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;

endmodule
`default_nettype wire
